// File: rtl/mux_pkg.sv
// ---------------------------------------------------------------------------
// mux_pkg: shared mode encodings and the rotating-priority search. rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Upper bound on channel count the search helper can handle.
  localparam int MAX_CH = 64;
  localparam int IDXW   = 6;

  typedef struct packed {
    logic            hit;
    logic [IDXW-1:0] idx;
  } rr_res_t;

  // First valid channel after ptr, searching ptr+1, ptr+2, ... wrapping at ch.
  function automatic rr_res_t next_rr(input int ptr, input logic [MAX_CH-1:0] vld, input int ch);
    rr_res_t res;
    int      k;
    res = '0;
    for (int i = 1; i <= MAX_CH; i++) begin
      if (i <= ch) begin
        k = ptr + i;
        if (k >= ch) k = k - ch;
        if (!res.hit && vld[k[IDXW-1:0]]) begin
          res.hit = 1'b1;
          res.idx = k[IDXW-1:0];
        end
      end
    end
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mux_rr_nt1_reg_arb.sv
// ---------------------------------------------------------------------------
// rr_arb_nb: round-robin pointer register plus rotating-priority search. rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rr_arb_nb
  import mux_pkg::*;
#(
  parameter  int CH   = 4,
  localparam int SELW = $clog2(CH)
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [CH-1:0]   REQ,
  input  logic            ADV,
  output logic            HIT,
  output logic [SELW-1:0] IDX
);

  logic [SELW-1:0]   ptr;
  logic [MAX_CH-1:0] req_pad;
  rr_res_t           res;
  logic              unused_idx;

  always_comb begin
    req_pad         = '0;
    req_pad[CH-1:0] = REQ;
  end

  assign res        = next_rr(int'(ptr), req_pad, CH);
  assign HIT        = res.hit;
  assign IDX        = res.idx[SELW-1:0];
  assign unused_idx = ^res.idx;

  // Reset to the last channel so the first search begins at channel 0.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ptr <= SELW'(CH - 1);
    end else if (ADV) begin
      ptr <= IDX;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mux_rr_nt1_reg.sv
// ---------------------------------------------------------------------------
// mux_rr_nt1_reg: registered N-to-1 valid/ready mux, fixed or round-robin. rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mux_rr_nt1_reg
  import mux_pkg::*;
#(
  parameter  int n    = 8,
  parameter  int CH   = 4,
  localparam int SELW = $clog2(CH)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              MODE,
  input  logic [SELW-1:0]   SEL,
  input  logic [CH*n-1:0]   D_IN,
  input  logic [CH-1:0]     D_VLD,
  output logic [CH-1:0]     D_RDY,
  output logic [n-1:0]      D_OUT,
  output logic [SELW-1:0]   OUT_CH,
  output logic              OUT_VLD,
  input  logic              OUT_RDY
);

  logic [n-1:0]        ch_data [CH];
  logic [2**SELW-1:0]  vld_ext;
  logic                rr_hit;
  logic [SELW-1:0]     rr_idx;
  logic                grant;
  logic [SELW-1:0]     gidx;
  logic                load_en;
  logic                xfer;
  logic                adv;

  for (genvar k = 0; k < CH; k++) begin : g_unpack
    assign ch_data[k] = D_IN[k*n +: n];
  end

  // Zero-padded valids make out-of-range SEL values read as "not valid".
  always_comb begin
    vld_ext         = '0;
    vld_ext[CH-1:0] = D_VLD;
  end

  rr_arb_nb #(.CH(CH)) u_arb (
    .CLK (CLK),
    .RST (RST),
    .REQ (D_VLD),
    .ADV (adv),
    .HIT (rr_hit),
    .IDX (rr_idx)
  );

  always_comb begin
    grant = 1'b0;
    gidx  = '0;
    if (MODE == MODE_RR) begin
      grant = rr_hit;
      gidx  = rr_idx;
    end else begin
      grant = vld_ext[SEL];
      gidx  = SEL;
    end
  end

  assign load_en = !OUT_VLD || OUT_RDY;
  assign xfer    = load_en && grant && !RST;
  assign adv     = xfer && (MODE == MODE_RR);

  always_comb begin
    D_RDY = '0;
    for (int k = 0; k < CH; k++) begin
      D_RDY[k] = xfer && (gidx == SELW'(k));
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      D_OUT   <= '0;
      OUT_CH  <= '0;
      OUT_VLD <= 1'b0;
    end else if (load_en) begin
      if (grant) begin
        D_OUT   <= ch_data[gidx];
        OUT_CH  <= gidx;
        OUT_VLD <= 1'b1;
      end else begin
        OUT_VLD <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire
